inst_fifo: RTL and testbench

Instruction buffer between the fetch stage and the dual-issue decode stage. Fetch writes up to two {PC, instruction} pairs per cycle; decode pops one entry (master only) or two (master plus slave) per cycle. The block generates the `fifo_empty` / `fifo_almost_empty` status consumed by slave-issue control, and the `fifo_almost_full` back-pressure consumed by fetch. Flush discards all contents on redirect (branch or exception).

---
 rtl/cpu_pkg.sv | 11 +
 rtl/inst_fifo_if.sv | 36 +++
 rtl/inst_fifo_ram.sv | 32 +++
 rtl/inst_fifo.sv | 100 ++++++++++
 tb/tb_inst_fifo.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Types shared between the fetch/decode pipeline blocks and the instruction buffer.
package cpu_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] inst;
    } fifo_entry_t;

    localparam int FIFO_DEPTH_DEFAULT = 16;

endpackage

// File: rtl/inst_fifo_if.sv
// Fetch/decode side of the instruction buffer: push pairs, issue acks, head reads and status.
interface inst_fifo_if;

    logic        flush;
    logic        write_en1;
    logic        write_en2;
    logic [31:0] write_addr1;
    logic [31:0] write_addr2;
    logic [31:0] write_inst1;
    logic [31:0] write_inst2;
    logic        master_is_issue;
    logic        slave_is_issue;
    logic [31:0] read_addr1;
    logic [31:0] read_inst1;
    logic [31:0] read_addr2;
    logic [31:0] read_inst2;
    logic        fifo_empty;
    logic        fifo_almost_empty;
    logic        fifo_almost_full;
    logic        fifo_full;

    modport master (
        output flush, write_en1, write_en2, write_addr1, write_addr2,
               write_inst1, write_inst2, master_is_issue, slave_is_issue,
        input  read_addr1, read_inst1, read_addr2, read_inst2,
               fifo_empty, fifo_almost_empty, fifo_almost_full, fifo_full
    );

    modport slave (
        input  flush, write_en1, write_en2, write_addr1, write_addr2,
               write_inst1, write_inst2, master_is_issue, slave_is_issue,
        output read_addr1, read_inst1, read_addr2, read_inst2,
               fifo_empty, fifo_almost_empty, fifo_almost_full, fifo_full
    );

endinterface

// File: rtl/inst_fifo_ram.sv
// 2-write / 2-read register array of fifo entries with asynchronous read.
module inst_fifo_ram
    import cpu_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     we1,
    input  logic                     we2,
    input  logic [$clog2(DEPTH)-1:0] waddr1,
    input  logic [$clog2(DEPTH)-1:0] waddr2,
    input  fifo_entry_t              wdata1,
    input  fifo_entry_t              wdata2,
    input  logic [$clog2(DEPTH)-1:0] raddr1,
    input  logic [$clog2(DEPTH)-1:0] raddr2,
    output fifo_entry_t              rdata1,
    output fifo_entry_t              rdata2
);

    fifo_entry_t mem [DEPTH];

    // NOTE: storage carries no reset; validity is tracked by the pointers and count,
    // so clearing every word would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (we1) mem[waddr1] <= wdata1;
        if (we2) mem[waddr2] <= wdata2;
    end

    assign rdata1 = mem[raddr1];
    assign rdata2 = mem[raddr2];

endmodule

// File: rtl/inst_fifo.sv
// Dual-push / dual-pop instruction buffer between fetch and dual-issue decode,
// with clipped pops, capacity-limited pushes, flush and registered status flags.
module inst_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEFAULT
) (
    input logic        clk,
    input logic        rst,
    inst_fifo_if.slave fifo
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic [1:0]    pop_req, pop_n;
    logic [1:0]    push_req, push_n;
    logic [CW-1:0] free_slots;

    fifo_entry_t   wdata1, wdata2, rdata1, rdata2;

    // NOTE: every combinational output is given a default before any branch so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        pop_req    = 2'(fifo.master_is_issue) + 2'(fifo.slave_is_issue);
        pop_n      = pop_req;
        push_req   = 2'd0;
        push_n     = 2'd0;
        free_slots = '0;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;

        if (CW'(pop_req) > count_q) pop_n = count_q[1:0];

        if (fifo.write_en1) push_req = fifo.write_en2 ? 2'd2 : 2'd1;

        // Slots freed by this cycle's pops can be refilled in the same cycle.
        free_slots = CW'(DEPTH) - count_q + CW'(pop_n);
        push_n     = (CW'(push_req) > free_slots) ? free_slots[1:0] : push_req;

        if (fifo.flush) begin
            pop_n    = 2'd0;
            push_n   = 2'd0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + PW'(push_n);
            rd_ptr_d = rd_ptr_q + PW'(pop_n);
            count_d  = count_q + CW'(push_n) - CW'(pop_n);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign wdata1 = '{addr: fifo.write_addr1, inst: fifo.write_inst1};
    assign wdata2 = '{addr: fifo.write_addr2, inst: fifo.write_inst2};

    inst_fifo_ram #(.DEPTH(DEPTH)) u_ram (
        .clk    (clk),
        .we1    (push_n != 2'd0),
        .we2    (push_n == 2'd2),
        .waddr1 (wr_ptr_q),
        .waddr2 (wr_ptr_q + PW'(1)),
        .wdata1 (wdata1),
        .wdata2 (wdata2),
        .raddr1 (rd_ptr_q),
        .raddr2 (rd_ptr_q + PW'(1)),
        .rdata1 (rdata1),
        .rdata2 (rdata2)
    );

    assign fifo.read_addr1 = (count_q != '0)      ? rdata1.addr : '0;
    assign fifo.read_inst1 = (count_q != '0)      ? rdata1.inst : '0;
    assign fifo.read_addr2 = (count_q >= CW'(2))  ? rdata2.addr : '0;
    assign fifo.read_inst2 = (count_q >= CW'(2))  ? rdata2.inst : '0;

    assign fifo.fifo_empty        = (count_q == '0);
    assign fifo.fifo_almost_empty = (count_q == CW'(1));
    assign fifo.fifo_almost_full  = (count_q >= CW'(DEPTH - 2));
    assign fifo.fifo_full         = (count_q == CW'(DEPTH));

endmodule

// File: tb/tb_inst_fifo.sv
// Self-checking bench for inst_fifo: vector table, directed corner sequences and
// randomized traffic against a queue-based reference model.
module tb_inst_fifo;
    import cpu_pkg::*;

    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    inst_fifo_if bus ();

    inst_fifo #(.DEPTH(DEPTH)) dut (
        .clk  (clk),
        .rst  (rst),
        .fifo (bus)
    );

    int checks   = 0;
    int failures = 0;
    fifo_entry_t model [$];

    typedef struct {
        logic        r, f, w1, w2;
        logic [31:0] a1, i1, a2, i2;
        logic        m, s;
        logic        e_empty, e_ae, e_af, e_full;
        logic [31:0] e_ra1, e_ri1, e_ra2, e_ri2;
    } vec_t;

    vec_t vecs [8];

    function automatic fifo_entry_t ent(logic [31:0] a, logic [31:0] i);
        fifo_entry_t e;
        e.addr = a;
        e.inst = i;
        return e;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, clock it, advance the reference model, settle.
    task automatic step(logic r, logic f, logic w1, logic w2, fifo_entry_t e1,
                        fifo_entry_t e2, logic m, logic s);
        int pops;
        int pushes;
        pops   = 0;
        pushes = int'(w1) + int'(w1 && w2);
        rst                 = r;
        bus.flush           = f;
        bus.write_en1       = w1;
        bus.write_en2       = w2;
        bus.write_addr1     = e1.addr;
        bus.write_inst1     = e1.inst;
        bus.write_addr2     = e2.addr;
        bus.write_inst2     = e2.inst;
        bus.master_is_issue = m;
        bus.slave_is_issue  = s;
        if (!r && !f) begin
            pops = int'(m) + int'(s);
            if (pops > model.size()) pops = model.size();
            assert (model.size() - pops + pushes <= DEPTH)
                else $error("push beyond capacity at count %0d", model.size());
        end
        @(posedge clk);
        if (r || f) begin
            model.delete();
        end else begin
            repeat (pops) void'(model.pop_front());
            if (w1 && model.size() < DEPTH) model.push_back(e1);
            if (w1 && w2 && model.size() < DEPTH) model.push_back(e2);
        end
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, ent(0, 0), ent(0, 0), 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, ent(0, 0), ent(0, 0), 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic check_model(string tag);
        fifo_entry_t h1;
        fifo_entry_t h2;
        h1 = ent(0, 0);
        h2 = ent(0, 0);
        if (model.size() > 0) h1 = model[0];
        if (model.size() > 1) h2 = model[1];
        check({tag, " read_addr1"}, bus.read_addr1, h1.addr);
        check({tag, " read_inst1"}, bus.read_inst1, h1.inst);
        check({tag, " read_addr2"}, bus.read_addr2, h2.addr);
        check({tag, " read_inst2"}, bus.read_inst2, h2.inst);
        check({tag, " empty"},  32'(bus.fifo_empty),        32'(model.size() == 0));
        check({tag, " aempty"}, 32'(bus.fifo_almost_empty), 32'(model.size() == 1));
        check({tag, " afull"},  32'(bus.fifo_almost_full),  32'(model.size() >= DEPTH - 2));
        check({tag, " full"},   32'(bus.fifo_full),         32'(model.size() == DEPTH));
    endtask

    initial begin
        bus.flush = 0; bus.write_en1 = 0; bus.write_en2 = 0;
        bus.write_addr1 = 0; bus.write_inst1 = 0; bus.write_addr2 = 0; bus.write_inst2 = 0;
        bus.master_is_issue = 0; bus.slave_is_issue = 0;

        vecs[0] = '{1,0,0,0, 32'h0,32'h0,32'h0,32'h0, 0,0, 1,0,0,0,
                    32'h0,32'h0,32'h0,32'h0};
        vecs[1] = '{0,0,1,1, 32'hBFC00000,32'h24080001,32'hBFC00004,32'h24090002, 0,0,
                    0,0,0,0, 32'hBFC00000,32'h24080001,32'hBFC00004,32'h24090002};
        vecs[2] = '{0,0,0,0, 32'h0,32'h0,32'h0,32'h0, 1,0, 0,1,0,0,
                    32'hBFC00004,32'h24090002,32'h0,32'h0};
        vecs[3] = '{0,0,0,0, 32'h0,32'h0,32'h0,32'h0, 1,1, 1,0,0,0,
                    32'h0,32'h0,32'h0,32'h0};
        vecs[4] = '{0,0,0,0, 32'h0,32'h0,32'h0,32'h0, 1,1, 1,0,0,0,
                    32'h0,32'h0,32'h0,32'h0};
        vecs[5] = '{0,0,1,0, 32'h10,32'h11,32'h0,32'h0, 0,0, 0,1,0,0,
                    32'h10,32'h11,32'h0,32'h0};
        vecs[6] = '{0,0,1,1, 32'h20,32'h21,32'h24,32'h25, 1,1, 0,0,0,0,
                    32'h20,32'h21,32'h24,32'h25};
        vecs[7] = '{0,1,1,1, 32'h30,32'h31,32'h34,32'h35, 1,0, 1,0,0,0,
                    32'h0,32'h0,32'h0,32'h0};

        for (int i = 0; i < 8; i++) begin
            step(vecs[i].r, vecs[i].f, vecs[i].w1, vecs[i].w2, ent(vecs[i].a1, vecs[i].i1),
                 ent(vecs[i].a2, vecs[i].i2), vecs[i].m, vecs[i].s);
            rst = 1'b0;
            check($sformatf("vec%0d empty", i),  32'(bus.fifo_empty),        32'(vecs[i].e_empty));
            check($sformatf("vec%0d aempty", i), 32'(bus.fifo_almost_empty), 32'(vecs[i].e_ae));
            check($sformatf("vec%0d afull", i),  32'(bus.fifo_almost_full),  32'(vecs[i].e_af));
            check($sformatf("vec%0d full", i),   32'(bus.fifo_full),         32'(vecs[i].e_full));
            check($sformatf("vec%0d ra1", i), bus.read_addr1, vecs[i].e_ra1);
            check($sformatf("vec%0d ri1", i), bus.read_inst1, vecs[i].e_ri1);
            check($sformatf("vec%0d ra2", i), bus.read_addr2, vecs[i].e_ra2);
            check($sformatf("vec%0d ri2", i), bus.read_inst2, vecs[i].e_ri2);
        end

        // Fill to DEPTH-2, then to full with single pushes.
        do_reset();
        for (int i = 0; i < (DEPTH - 2) / 2; i++)
            step(0, 0, 1, 1, ent(32'h1000 + 8 * i, i), ent(32'h1004 + 8 * i, 100 + i), 0, 0);
        check("fill14 afull", 32'(bus.fifo_almost_full), 32'd1);
        check("fill14 full",  32'(bus.fifo_full),        32'd0);
        step(0, 0, 1, 0, ent(32'h2000, 32'h1), ent(0, 0), 0, 0);
        check("fill15 afull", 32'(bus.fifo_almost_full), 32'd1);
        check("fill15 full",  32'(bus.fifo_full),        32'd0);
        step(0, 0, 1, 0, ent(32'h2004, 32'h2), ent(0, 0), 0, 0);
        check("fill16 full",  32'(bus.fifo_full),        32'd1);
        check_model("fill16");
        step(0, 0, 1, 1, ent(32'h3000, 32'h3), ent(32'h3004, 32'h4), 1, 1);
        check_model("full swap");

        // Bring both pointers to DEPTH-1, then push a pair across the wrap.
        do_reset();
        for (int k = 0; k < DEPTH - 1; k++)
            step(0, 0, 1, 0, ent(32'h200 + 4 * k, k), ent(0, 0), k > 0, 0);
        step(0, 0, 0, 0, ent(0, 0), ent(0, 0), 1, 0);
        check("wrap pre empty", 32'(bus.fifo_empty), 32'd1);
        step(0, 0, 1, 1, ent(32'h100, 32'hAAAA0001), ent(32'h104, 32'hAAAA0002), 0, 0);
        check("wrap ra1", bus.read_addr1, 32'h100);
        check("wrap ra2", bus.read_addr2, 32'h104);
        check("wrap ri2", bus.read_inst2, 32'hAAAA0002);
        step(0, 0, 0, 0, ent(0, 0), ent(0, 0), 1, 1);
        check("wrap pop2 empty", 32'(bus.fifo_empty), 32'd1);

        // Push-2 and pop-2 together at count 4.
        do_reset();
        step(0, 0, 1, 1, ent(32'hA0, 0), ent(32'hA4, 1), 0, 0);
        step(0, 0, 1, 1, ent(32'hA8, 2), ent(32'hAC, 3), 0, 0);
        step(0, 0, 1, 1, ent(32'hB0, 4), ent(32'hB4, 5), 1, 1);
        check("pp4 ra1", bus.read_addr1, 32'hA8);
        check("pp4 ra2", bus.read_addr2, 32'hAC);
        check("pp4 afull", 32'(bus.fifo_almost_full), 32'd0);
        check_model("pp4");

        // Flush at count 7 while pushing, then reset mid-stream.
        do_reset();
        for (int i = 0; i < 3; i++) step(0, 0, 1, 1, ent(32'hC0 + 8 * i, i), ent(32'hC4 + 8 * i, i), 0, 0);
        step(0, 0, 1, 0, ent(32'hF0, 7), ent(0, 0), 0, 0);
        check_model("cnt7");
        step(0, 1, 1, 1, ent(32'hD0, 8), ent(32'hD4, 9), 1, 0);
        check("flush empty", 32'(bus.fifo_empty), 32'd1);
        check("flush ra1", bus.read_addr1, 32'h0);
        check("flush ri1", bus.read_inst1, 32'h0);
        check("flush ra2", bus.read_addr2, 32'h0);
        check("flush ri2", bus.read_inst2, 32'h0);
        step(0, 0, 1, 1, ent(32'hE0, 1), ent(32'hE4, 2), 0, 0);
        step(0, 0, 1, 1, ent(32'hE8, 3), ent(32'hEC, 4), 1, 0);
        step(1, 0, 1, 1, ent(32'hF8, 5), ent(32'hFC, 6), 1, 1);
        rst = 1'b0;
        check("rst empty",  32'(bus.fifo_empty),        32'd1);
        check("rst aempty", 32'(bus.fifo_almost_empty), 32'd0);
        check("rst afull",  32'(bus.fifo_almost_full),  32'd0);
        check("rst full",   32'(bus.fifo_full),         32'd0);
        check("rst ra1", bus.read_addr1, 32'h0);
        check("rst ra2", bus.read_addr2, 32'h0);
        idle();
        check_model("post rst idle");

        // Randomized traffic against the queue model.
        for (int c = 0; c < 3000; c++) begin
            logic r, f, w1, w2, m, s;
            r  = ($urandom_range(0, 199) == 0);
            f  = ($urandom_range(0, 39) == 0);
            w1 = ($urandom_range(0, 9) < 6) && (model.size() < DEPTH - 2);
            w2 = w1 && ($urandom_range(0, 1) == 1);
            m  = ($urandom_range(0, 1) == 1);
            s  = m && ($urandom_range(0, 1) == 1);
            step(r, f, w1, w2, ent($urandom, $urandom), ent($urandom, $urandom), m, s);
            rst = 1'b0;
            check_model("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
